multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Multicycle control unit for the RV32I-subset core. It sequences a shared datapath (one memory for instructions and data, one ALU, plus IR, PC and register file) through the fetch, decode, execute, memory and writeback steps. It replaces the single-cycle controlUnit when the core runs in multicycle mode. It consumes the IR opcode/funct fields and the ALU zero flag, and drives every datapath enable and mux select.

Parameters:
none

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; FSM returns to FETCH
op  in  7  opcode from instruction register
funct3  in  3  IR funct3
funct7  in  1  IR bit 30 (funct7[5])
zero  in  1  ALU zero flag
pcWrite  out  1  PC register enable
adrSrc  out  1  memory address mux: 0=PC, 1=ALUOut
memWrite  out  1  data memory write enable
irWrite  out  1  IR/oldPC enable
resSrc  out  2  result mux: 00=ALUOut, 01=memData, 10=ALUResult
aluSrcA  out  2  00=PC, 01=oldPC, 10=rs1 reg
aluSrcB  out  2  00=rs2 reg, 01=immExt, 10=constant 4
regWrite  out  1  register file write enable
inmSrc  out  2  immediate type: 00=I, 01=S, 10=B, 11=J
ALUcontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
state  out  4  current state (debug/verification)
instrDone  out  1  high in the last state of each instruction
illegal  out  1  high in DECODE when the opcode is unsupported

Behaviour:
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, jal 1101111, beq 1100011.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Codes 11-15 are unreachable; if entered, next state is FETCH and all enables are 0.
- Transitions:
  - FETCH->DECODE.
  - DECODE: lw/sw->MEMADR, R->EXECUTER, I->EXECUTEI, jal->JAL, beq->BEQ, any other opcode->FETCH.
  - MEMADR: lw->MEMREAD, sw->MEMWRITE.
  - MEMREAD->MEMWB->FETCH. MEMWRITE->FETCH.
  - EXECUTER/EXECUTEI/JAL->ALUWB->FETCH. BEQ->FETCH.
- Moore outputs per state. Any signal not listed is 0.
  - FETCH: irWrite=1, aluSrcB=10, resSrc=10, pcUpdate=1, ALUop=00.
  - DECODE: aluSrcA=01, aluSrcB=01, ALUop=00 (branch/jump target).
  - MEMADR: aluSrcA=10, aluSrcB=01, ALUop=00.
  - MEMREAD: adrSrc=1, resSrc=00.
  - MEMWB: resSrc=01, regWrite=1.
  - MEMWRITE: adrSrc=1, memWrite=1.
  - EXECUTER: aluSrcA=10, aluSrcB=00, ALUop=10.
  - EXECUTEI: aluSrcA=10, aluSrcB=01, ALUop=10.
  - ALUWB: resSrc=00, regWrite=1.
  - JAL: aluSrcA=01, aluSrcB=10, resSrc=00, pcUpdate=1.
  - BEQ: aluSrcA=10, aluSrcB=00, ALUop=01, branch=1.
- pcWrite = pcUpdate | (branch & zero). BEQ is the only state where the same-cycle zero input matters.
- ALU decode (combinational from ALUop):
  - ALUop 00 -> add; 01 -> sub.
  - ALUop 10, by funct3: 000 -> sub if op[5]&funct7, else add; 010 -> slt; 110 -> or; 111 -> and; other funct3 -> add.
- inmSrc is combinational from op: lw/I -> 00, sw -> 01, beq -> 10, jal -> 11, other -> 00.
- instrDone is high in MEMWB, MEMWRITE, ALUWB and BEQ, and in DECODE when illegal.
- Latency in cycles: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- Reset (asynchronous, any cycle including mid-instruction):
  - state=FETCH immediately.
  - While reset is high, pcWrite, irWrite, regWrite, memWrite, instrDone and illegal are forced to 0. Other outputs take their FETCH values.
  - The first rising edge after reset deasserts performs the fetch.
- The controller assumes op/funct fields are stable from DECODE until the instruction ends (IR held because irWrite=0).

Test Plan:
- reset=1 mid-MEMREAD -> state=0 asynchronously, all write enables 0; release reset with op=lw -> state sequence 0,1,2,3,4,0. regWrite=1 only in MEMWB with resSrc=01. instrDone pulses once.
- sw (op=0100011) -> states 0,1,2,5,0. memWrite=1 only in state 5 with adrSrc=1. inmSrc=01 throughout.
- R-type sub (op=0110011, funct3=000, funct7=1) -> in EXECUTER ALUcontrol=001. Same instruction with funct7=0 -> 000. funct3=111 -> 010. I-ALU addi with funct7=1 -> 000 (no sub).
- beq zero=1 -> in BEQ pcWrite=1, ALUcontrol=001, 3 cycles total. Repeat with zero=0 -> pcWrite=0 in BEQ.
- jal (op=1101111) -> states 0,1,9,7,0. pcWrite=1 in JAL. regWrite=1 in ALUWB. inmSrc=11.
- op=1111111 -> states 0,1,0. illegal=1 and instrDone=1 in DECODE. No write enable asserted after FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I-subset controller: sequences the shared memory/ALU datapath
// through fetch, decode, execute, memory and writeback with Moore outputs.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic [1:0] resSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic       regWrite,
    output logic [1:0] inmSrc,
    output logic [2:0] ALUcontrol,
    output logic [3:0] state,
    output logic       instrDone,
    output logic       illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       w_pc_update;
    logic       w_branch;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_res_src;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic       w_reg_write;
    logic [1:0] w_alu_op;
    logic       w_end_state;
    logic       w_known_op;
    logic       w_illegal;
    logic       w_sub;
    logic [2:0] w_alu_ctrl;
    logic [1:0] w_imm_src;

    assign w_known_op = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                        (op == OP_I)  || (op == OP_JAL) || (op == OP_BEQ);

    assign w_illegal = (r_state == S_DECODE) && !w_known_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_adr_src   = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_res_src   = 2'b00;
        w_src_a     = 2'b00;
        w_src_b     = 2'b00;
        w_reg_write = 1'b0;
        w_alu_op    = 2'b00;
        w_end_state = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_next      = S_DECODE;
                w_ir_write  = 1'b1;
                w_src_b     = 2'b10;
                w_res_src   = 2'b10;
                w_pc_update = 1'b1;
            end
            S_DECODE: begin
                // ALU precomputes oldPC + imm so BEQ/JAL find their target in ALUOut
                w_src_a = 2'b01;
                w_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_src_a = 2'b10;
                w_src_b = 2'b01;
                if (op == OP_LW) begin
                    w_next = S_MEMREAD;
                end else if (op == OP_SW) begin
                    w_next = S_MEMWRITE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMREAD: begin
                w_next    = S_MEMWB;
                w_adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_res_src   = 2'b01;
                w_reg_write = 1'b1;
                w_end_state = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_end_state = 1'b1;
            end
            S_EXECUTER: begin
                w_next   = S_ALUWB;
                w_src_a  = 2'b10;
                w_alu_op = 2'b10;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_end_state = 1'b1;
            end
            S_EXECUTEI: begin
                w_next   = S_ALUWB;
                w_src_a  = 2'b10;
                w_src_b  = 2'b01;
                w_alu_op = 2'b10;
            end
            S_JAL: begin
                w_next      = S_ALUWB;
                w_src_a     = 2'b01;
                w_src_b     = 2'b10;
                w_pc_update = 1'b1;
            end
            S_BEQ: begin
                w_src_a     = 2'b10;
                w_alu_op    = 2'b01;
                w_branch    = 1'b1;
                w_end_state = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Subtraction only for R-type (op[5]=1); addi with bit 30 set stays an add
    assign w_sub = op[5] & funct7;

    always_comb begin
        w_alu_ctrl = 3'b000;
        case (w_alu_op)
            2'b00: w_alu_ctrl = 3'b000;
            2'b01: w_alu_ctrl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  w_alu_ctrl = w_sub ? 3'b001 : 3'b000;
                    3'b010:  w_alu_ctrl = 3'b101;
                    3'b110:  w_alu_ctrl = 3'b011;
                    3'b111:  w_alu_ctrl = 3'b010;
                    default: w_alu_ctrl = 3'b000;
                endcase
            end
            default: w_alu_ctrl = 3'b000;
        endcase
    end

    always_comb begin
        w_imm_src = 2'b00;
        case (op)
            OP_LW, OP_I: w_imm_src = 2'b00;
            OP_SW:       w_imm_src = 2'b01;
            OP_BEQ:      w_imm_src = 2'b10;
            OP_JAL:      w_imm_src = 2'b11;
            default:     w_imm_src = 2'b00;
        endcase
    end

    // Enables are masked by reset so nothing is written while it is held high
    assign pcWrite    = ~reset & (w_pc_update | (w_branch & zero));
    assign irWrite    = ~reset & w_ir_write;
    assign regWrite   = ~reset & w_reg_write;
    assign memWrite   = ~reset & w_mem_write;
    assign instrDone  = ~reset & (w_end_state | w_illegal);
    assign illegal    = ~reset & w_illegal;
    assign adrSrc     = w_adr_src;
    assign resSrc     = w_res_src;
    assign aluSrcA    = w_src_a;
    assign aluSrcB    = w_src_b;
    assign inmSrc     = w_imm_src;
    assign ALUcontrol = w_alu_ctrl;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle vector table over whole
// instructions plus hand-written asynchronous reset sequences.
module tb_multicycle_control_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       zero;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, instrDone, illegal;
    logic [1:0] resSrc, aluSrcA, aluSrcB, inmSrc;
    logic [2:0] ALUcontrol;
    logic [3:0] state;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite),
        .irWrite(irWrite), .resSrc(resSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .regWrite(regWrite), .inmSrc(inmSrc), .ALUcontrol(ALUcontrol),
        .state(state), .instrDone(instrDone), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {st, pcw, adr, mw, irw, res, srcA, srcB, rw, imm, alu, done, ill}
    typedef struct packed {
        logic [3:0] st;
        logic [3:0] en;
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic       rw;
        logic [1:0] imm;
        logic [2:0] alu;
        logic [1:0] di;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [1:0] f7z;
        out_t       e;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f3,
                                input logic [1:0] f7z, input logic [3:0] st,
                                input logic [3:0] en, input logic [1:0] res,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic rw, input logic [1:0] imm,
                                input logic [2:0] alu, input logic [1:0] di);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7z = f7z;
        v.e  = '{st, en, res, a, b, rw, imm, alu, di};
        return v;
    endfunction

    function automatic out_t sample();
        out_t s;
        s = '{state, {pcWrite, adrSrc, memWrite, irWrite}, resSrc, aluSrcA, aluSrcB,
              regWrite, inmSrc, ALUcontrol, {instrDone, illegal}};
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        out_t act;

        // lw
        tbl.push_back(mk(LW, 3'b010, 2'b00, 4'd0, 4'b1001, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(LW, 3'b010, 2'b00, 4'd1, 4'b0000, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(LW, 3'b010, 2'b00, 4'd2, 4'b0000, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(LW, 3'b010, 2'b00, 4'd3, 4'b0100, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(LW, 3'b010, 2'b00, 4'd4, 4'b0000, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, 2'b10));
        // sw
        tbl.push_back(mk(SW, 3'b010, 2'b00, 4'd0, 4'b1001, 2'b10, 2'b00, 2'b10, 1'b0, 2'b01, 3'b000, 2'b00));
        tbl.push_back(mk(SW, 3'b010, 2'b00, 4'd1, 4'b0000, 2'b00, 2'b01, 2'b01, 1'b0, 2'b01, 3'b000, 2'b00));
        tbl.push_back(mk(SW, 3'b010, 2'b00, 4'd2, 4'b0000, 2'b00, 2'b10, 2'b01, 1'b0, 2'b01, 3'b000, 2'b00));
        tbl.push_back(mk(SW, 3'b010, 2'b00, 4'd5, 4'b0110, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 2'b10));
        // R sub, with zero=1 to show it does not leak into pcWrite
        tbl.push_back(mk(RT, 3'b000, 2'b11, 4'd0, 4'b1001, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(RT, 3'b000, 2'b11, 4'd1, 4'b0000, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(RT, 3'b000, 2'b11, 4'd6, 4'b0000, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 3'b001, 2'b00));
        tbl.push_back(mk(RT, 3'b000, 2'b11, 4'd7, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, 2'b10));
        // R add
        tbl.push_back(mk(RT, 3'b000, 2'b00, 4'd0, 4'b1001, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(RT, 3'b000, 2'b00, 4'd1, 4'b0000, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(RT, 3'b000, 2'b00, 4'd6, 4'b0000, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(RT, 3'b000, 2'b00, 4'd7, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, 2'b10));
        // R and
        tbl.push_back(mk(RT, 3'b111, 2'b00, 4'd0, 4'b1001, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(RT, 3'b111, 2'b00, 4'd1, 4'b0000, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(RT, 3'b111, 2'b00, 4'd6, 4'b0000, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 3'b010, 2'b00));
        tbl.push_back(mk(RT, 3'b111, 2'b00, 4'd7, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, 2'b10));
        // addi with bit 30 set stays add
        tbl.push_back(mk(IT, 3'b000, 2'b10, 4'd0, 4'b1001, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(IT, 3'b000, 2'b10, 4'd1, 4'b0000, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(IT, 3'b000, 2'b10, 4'd8, 4'b0000, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(IT, 3'b000, 2'b10, 4'd7, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, 2'b10));
        // beq taken
        tbl.push_back(mk(BEQ, 3'b000, 2'b01, 4'd0, 4'b1001, 2'b10, 2'b00, 2'b10, 1'b0, 2'b10, 3'b000, 2'b00));
        tbl.push_back(mk(BEQ, 3'b000, 2'b01, 4'd1, 4'b0000, 2'b00, 2'b01, 2'b01, 1'b0, 2'b10, 3'b000, 2'b00));
        tbl.push_back(mk(BEQ, 3'b000, 2'b01, 4'd10, 4'b1000, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 3'b001, 2'b10));
        // beq not taken
        tbl.push_back(mk(BEQ, 3'b000, 2'b00, 4'd0, 4'b1001, 2'b10, 2'b00, 2'b10, 1'b0, 2'b10, 3'b000, 2'b00));
        tbl.push_back(mk(BEQ, 3'b000, 2'b00, 4'd1, 4'b0000, 2'b00, 2'b01, 2'b01, 1'b0, 2'b10, 3'b000, 2'b00));
        tbl.push_back(mk(BEQ, 3'b000, 2'b00, 4'd10, 4'b0000, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 3'b001, 2'b10));
        // jal
        tbl.push_back(mk(JAL, 3'b000, 2'b00, 4'd0, 4'b1001, 2'b10, 2'b00, 2'b10, 1'b0, 2'b11, 3'b000, 2'b00));
        tbl.push_back(mk(JAL, 3'b000, 2'b00, 4'd1, 4'b0000, 2'b00, 2'b01, 2'b01, 1'b0, 2'b11, 3'b000, 2'b00));
        tbl.push_back(mk(JAL, 3'b000, 2'b00, 4'd9, 4'b1000, 2'b00, 2'b01, 2'b10, 1'b0, 2'b11, 3'b000, 2'b00));
        tbl.push_back(mk(JAL, 3'b000, 2'b00, 4'd7, 4'b0000, 2'b00, 2'b00, 2'b00, 1'b1, 2'b11, 3'b000, 2'b10));
        // unsupported opcode
        tbl.push_back(mk(BAD, 3'b000, 2'b00, 4'd0, 4'b1001, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 2'b00));
        tbl.push_back(mk(BAD, 3'b000, 2'b00, 4'd1, 4'b0000, 2'b00, 2'b01, 2'b01, 1'b0, 2'b00, 3'b000, 2'b11));
        tbl.push_back(mk(LW, 3'b010, 2'b00, 4'd0, 4'b1001, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 2'b00));

        // Power-up reset: FETCH values on muxes, every enable low
        reset = 1'b1; op = LW; funct3 = 3'b010; funct7 = 1'b0; zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_enables", 32'({pcWrite, irWrite, regWrite, memWrite, instrDone, illegal}), 32'd0);
        chk("reset_muxes", 32'({aluSrcB, resSrc, aluSrcA}), 32'({2'b10, 2'b10, 2'b00}));

        // Run lw into MEMREAD, then hit reset mid-cycle
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_memread", 32'(state), 32'd3);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_state", 32'(state), 32'd0);
        chk("async_reset_enables", 32'({pcWrite, irWrite, regWrite, memWrite, instrDone, illegal}), 32'd0);
        @(negedge clk);
        chk("reset_held_state", 32'(state), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            op     = tbl[i].op;
            funct3 = tbl[i].f3;
            funct7 = tbl[i].f7z[1];
            zero   = tbl[i].f7z[0];
            #1;
            act = sample();
            n_vec++;
            if (act !== tbl[i].e) begin
                n_err++;
                $display("FAIL vec%0d: got %h expected %h", i, act, tbl[i].e);
            end
            @(negedge clk);
        end

        // Now in DECODE of the last lw; an unsupported opcode here flags illegal,
        // and reset must clear both illegal and instrDone immediately.
        op = BAD;
        #1;
        chk("decode_illegal", 32'({state, illegal, instrDone}), 32'({4'd1, 1'b1, 1'b1}));
        reset = 1'b1;
        #1;
        chk("reset_masks_illegal", 32'({state, illegal, instrDone}), 32'({4'd0, 1'b0, 1'b0}));
        @(negedge clk);
        reset = 1'b0;
        op = LW;
        @(negedge clk);
        chk("fetch_after_reset", 32'(state), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
